// File: rtl/alu_exec_ctrl_if.sv
// Decode-to-execute op handshake: one data-processing op per
// in_valid & in_ready transfer.
interface alu_exec_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_cond;
   logic [3:0]        in_opcode;
   logic              in_s;
   logic [REG_AW-1:0] in_rd;
   logic [DATA_W-1:0] in_op1;
   logic [DATA_W-1:0] in_op2;
   logic              in_shc;

   modport master (
      output in_valid, in_cond, in_opcode, in_s,
      output in_rd, in_op1, in_op2, in_shc,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_cond, in_opcode, in_s,
      input  in_rd, in_op1, in_op2, in_shc,
      output in_ready
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the 32-bit ALU: condition check, one
// ALU cycle, then register writeback and NZCV update.
module alu_exec_ctrl #(
   parameter int         DATA_W      = 32,
   parameter int         REG_AW      = 4,
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_exec_ctrl_if.slave    op_if,
   input  logic              flush,
   output logic [3:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_operand1,
   output logic [DATA_W-1:0] alu_operand2,
   output logic              alu_carry_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry_out,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        flags_nzcv,
   output logic              done,
   output logic              cond_pass
);

   localparam int MSB = DATA_W - 1;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WB
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        opc_q, opc_d;
   logic              s_q, s_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              shc_q, shc_d;
   logic              pass_q, pass_d;
   logic [3:0]        aop_q, aop_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              cout_q, cout_d;
   logic [3:0]        flags_q, flags_d;

   logic       f_n, f_z, f_c, f_v;
   logic       cond_ok;
   logic [3:0] aop_map;
   logic       is_test, is_arith, is_add, is_swap, upd;
   logic       x_msb, y_msb, r_msb, v_new, c_new;

   assign {f_n, f_z, f_c, f_v} = flags_q;

   always_comb begin
      cond_ok = 1'b0;
      unique case (op_if.in_cond)
         4'h0: cond_ok = f_z;
         4'h1: cond_ok = !f_z;
         4'h2: cond_ok = f_c;
         4'h3: cond_ok = !f_c;
         4'h4: cond_ok = f_n;
         4'h5: cond_ok = !f_n;
         4'h6: cond_ok = f_v;
         4'h7: cond_ok = !f_v;
         4'h8: cond_ok = f_c && !f_z;
         4'h9: cond_ok = !f_c || f_z;
         4'hA: cond_ok = f_n == f_v;
         4'hB: cond_ok = f_n != f_v;
         4'hC: cond_ok = !f_z && (f_n == f_v);
         4'hD: cond_ok = f_z || (f_n != f_v);
         4'hE: cond_ok = 1'b1;
         4'hF: cond_ok = 1'b0;
      endcase
   end

   // Compare/test ops reuse the ALU's plain logic/arith encodings.
   always_comb begin
      aop_map = op_if.in_opcode;
      unique case (op_if.in_opcode)
         4'h8:    aop_map = 4'h0;
         4'h9:    aop_map = 4'h1;
         4'hA:    aop_map = 4'h2;
         4'hB:    aop_map = 4'h4;
         default: aop_map = op_if.in_opcode;
      endcase
   end

   assign is_test  = opc_q[3:2] == 2'b10;
   assign is_arith = opc_q inside {[4'h2:4'h7], 4'hA, 4'hB};
   assign is_add   = opc_q inside {4'h4, 4'h5, 4'hB};
   assign is_swap  = opc_q inside {4'h3, 4'h7};
   assign upd      = s_q || is_test;

   // Reverse-subtracts issue the operands swapped, so swap back.
   assign x_msb = is_swap ? b_q[MSB] : a_q[MSB];
   assign y_msb = is_swap ? a_q[MSB] : b_q[MSB];
   assign r_msb = res_q[MSB];

   always_comb begin
      v_new = f_v;
      c_new = shc_q;
      if (is_arith) begin
         c_new = cout_q;
         if (is_add)
            v_new = (x_msb == y_msb) && (r_msb != x_msb);
         else
            v_new = (x_msb != y_msb) && (r_msb != x_msb);
      end
   end

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      s_d     = s_q;
      rd_d    = rd_q;
      shc_d   = shc_q;
      pass_d  = pass_q;
      aop_d   = aop_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cout_d  = cout_q;
      flags_d = flags_q;
      unique case (state_q)
         IDLE: begin
            if (op_if.in_valid) begin
               opc_d  = op_if.in_opcode;
               s_d    = op_if.in_s;
               rd_d   = op_if.in_rd;
               shc_d  = op_if.in_shc;
               pass_d = cond_ok;
               if (cond_ok) begin
                  aop_d   = aop_map;
                  a_d     = op_if.in_op1;
                  b_d     = op_if.in_op2;
                  state_d = EXEC;
               end else begin
                  state_d = WB;
               end
            end
         end
         EXEC: begin
            res_d   = alu_result;
            cout_d  = alu_carry_out;
            state_d = flush ? IDLE : WB;
         end
         WB: begin
            state_d = IDLE;
            if (!flush && pass_q && upd)
               flags_d = {r_msb, res_q == '0, c_new, v_new};
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opc_q   <= 4'hD;
         s_q     <= 1'b0;
         rd_q    <= '0;
         shc_q   <= 1'b0;
         pass_q  <= 1'b0;
         aop_q   <= 4'hD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         flags_q <= FLAGS_RESET;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         s_q     <= s_d;
         rd_q    <= rd_d;
         shc_q   <= shc_d;
         pass_q  <= pass_d;
         aop_q   <= aop_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         flags_q <= flags_d;
      end
   end

   assign op_if.in_ready = state_q == IDLE;
   assign alu_opcode     = aop_q;
   assign alu_operand1   = a_q;
   assign alu_operand2   = b_q;
   assign alu_carry_in   = f_c;
   assign done           = (state_q == WB) && !flush;
   assign cond_pass      = done && pass_q;
   assign wb_en          = cond_pass && !is_test;
   assign wb_addr        = rd_q;
   assign wb_data        = res_q;
   assign flags_nzcv     = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed cases plus random ops checked
// against an arithmetic reference model of the condition/flag rules.
module tb_alu_exec_ctrl;
   localparam int DW = 32;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   alu_exec_ctrl_if #(.DATA_W(DW), .REG_AW(AW)) op_if ();

   logic [3:0]    alu_opcode;
   logic [DW-1:0] alu_operand1, alu_operand2;
   logic          alu_carry_in;
   logic [DW-1:0] alu_result;
   logic          alu_carry_out;
   logic          wb_en, done, cond_pass;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [3:0]    flags_nzcv;

   alu_exec_ctrl #(
      .DATA_W(DW), .REG_AW(AW), .FLAGS_RESET(4'b0000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .op_if(op_if), .flush(flush),
      .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
      .alu_operand2(alu_operand2), .alu_carry_in(alu_carry_in),
      .alu_result(alu_result), .alu_carry_out(alu_carry_out),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flags_nzcv(flags_nzcv), .done(done), .cond_pass(cond_pass)
   );

   // Stand-in for the external combinational ALU.
   logic [32:0] alu_t;
   always_comb begin
      alu_t = '0;
      case (alu_opcode)
         4'h0: alu_t = {1'b0, alu_operand1 & alu_operand2};
         4'h1: alu_t = {1'b0, alu_operand1 ^ alu_operand2};
         4'h2: alu_t = {1'b0, alu_operand1} + {1'b0, ~alu_operand2} + 33'd1;
         4'h3: alu_t = {1'b0, alu_operand2} + {1'b0, ~alu_operand1} + 33'd1;
         4'h4: alu_t = {1'b0, alu_operand1} + {1'b0, alu_operand2};
         4'h5: alu_t = {1'b0, alu_operand1} + {1'b0, alu_operand2}
                       + {32'd0, alu_carry_in};
         4'h6: alu_t = {1'b0, alu_operand1} + {1'b0, ~alu_operand2}
                       + {32'd0, alu_carry_in};
         4'h7: alu_t = {1'b0, alu_operand2} + {1'b0, ~alu_operand1}
                       + {32'd0, alu_carry_in};
         4'hC: alu_t = {1'b0, alu_operand1 | alu_operand2};
         4'hD: alu_t = {1'b0, alu_operand2};
         4'hE: alu_t = {1'b0, alu_operand1 & ~alu_operand2};
         4'hF: alu_t = {1'b0, ~alu_operand2};
         default: alu_t = '0;
      endcase
   end
   assign alu_result    = alu_t[31:0];
   assign alu_carry_out = alu_t[32];

   int n_chk = 0;
   int n_fail = 0;
   logic [3:0] m_flags = 4'b0000;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: ARM semantics via wide signed/unsigned integer math.
   function automatic void model(
      input  logic [3:0]  cond, opc,
      input  logic        s,
      input  logic [31:0] a, b,
      input  logic        shc,
      input  logic [3:0]  fl,
      output logic        pass,
      output logic        wbe,
      output logic [31:0] res,
      output logic [3:0]  nf
   );
      logic n, z, c, v, arith, addt, cout, vout;
      longint ua, ub, sa, sb, u, sr, ci;
      {n, z, c, v} = fl;
      case (cond)
         4'h0: pass = z;
         4'h1: pass = !z;
         4'h2: pass = c;
         4'h3: pass = !c;
         4'h4: pass = n;
         4'h5: pass = !n;
         4'h6: pass = v;
         4'h7: pass = !v;
         4'h8: pass = c && !z;
         4'h9: pass = !c || z;
         4'hA: pass = n == v;
         4'hB: pass = n != v;
         4'hC: pass = !z && (n == v);
         4'hD: pass = z || (n != v);
         4'hE: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ci = c ? 1 : 0;
      arith = 1'b1;
      u = 0;
      sr = 0;
      res = '0;
      case (opc)
         4'h2, 4'hA: begin u = ua - ub; sr = sa - sb; end
         4'h3: begin u = ub - ua; sr = sb - sa; end
         4'h4, 4'hB: begin u = ua + ub; sr = sa + sb; end
         4'h5: begin u = ua + ub + ci; sr = sa + sb + ci; end
         4'h6: begin u = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); end
         4'h7: begin u = ub - ua - (1 - ci); sr = sb - sa - (1 - ci); end
         default: arith = 1'b0;
      endcase
      addt = opc inside {4'h4, 4'h5, 4'hB};
      cout = addt ? (u >= 64'sd4294967296) : (u >= 0);
      vout = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      if (arith) res = u[31:0];
      else begin
         case (opc)
            4'h0, 4'h8: res = a & b;
            4'h1, 4'h9: res = a ^ b;
            4'hC: res = a | b;
            4'hD: res = b;
            4'hE: res = a & ~b;
            default: res = ~b;
         endcase
      end
      nf = fl;
      if (s || opc inside {[4'h8:4'hB]})
         nf = {res[31], res == 32'd0, arith ? cout : shc,
               arith ? vout : v};
      wbe = pass && !(opc inside {[4'h8:4'hB]});
   endfunction

   // fl_at: 0 none, 1 flush in EXEC, 2 flush in WB, 3 flush at accept
   task automatic do_op(input logic [3:0] cond, opc, input logic s,
                        input logic [3:0] rd, input logic [31:0] a, b,
                        input logic shc, input int fl_at);
      logic pass, wbe;
      logic [31:0] res;
      logic [3:0] nf, eop;
      model(cond, opc, s, a, b, shc, m_flags, pass, wbe, res, nf);
      eop = (opc == 4'h8) ? 4'h0 : (opc == 4'h9) ? 4'h1 :
            (opc == 4'hA) ? 4'h2 : (opc == 4'hB) ? 4'h4 : opc;
      chk("ready_idle", 32'(op_if.in_ready), 32'd1);
      op_if.in_valid  = 1'b1;
      op_if.in_cond   = cond;
      op_if.in_opcode = opc;
      op_if.in_s      = s;
      op_if.in_rd     = rd;
      op_if.in_op1    = a;
      op_if.in_op2    = b;
      op_if.in_shc    = shc;
      if (fl_at == 3) flush = 1'b1;
      tick();
      op_if.in_valid = 1'b0;
      flush = 1'b0;
      #1;
      if (!pass) begin
         chk("fail_done", 32'(done), 32'd1);
         chk("fail_cpass", 32'(cond_pass), 32'd0);
         chk("fail_wben", 32'(wb_en), 32'd0);
         tick();
         chk("fail_ready", 32'(op_if.in_ready), 32'd1);
         chk("fail_flags", 32'(flags_nzcv), 32'(m_flags));
         return;
      end
      chk("exec_ready", 32'(op_if.in_ready), 32'd0);
      chk("exec_aop", 32'(alu_opcode), 32'(eop));
      chk("exec_op1", alu_operand1, a);
      chk("exec_op2", alu_operand2, b);
      chk("exec_cin", 32'(alu_carry_in), 32'(m_flags[1]));
      chk("exec_done", 32'(done), 32'd0);
      if (fl_at == 1) flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      if (fl_at == 1) begin
         chk("fle_ready", 32'(op_if.in_ready), 32'd1);
         chk("fle_done", 32'(done), 32'd0);
         chk("fle_wben", 32'(wb_en), 32'd0);
         chk("fle_flags", 32'(flags_nzcv), 32'(m_flags));
         return;
      end
      if (fl_at == 2) begin
         flush = 1'b1;
         #1;
      end
      chk("wb_done", 32'(done), 32'(fl_at != 2));
      chk("wb_cpass", 32'(cond_pass), 32'(fl_at != 2));
      chk("wb_en", 32'(wb_en), 32'(wbe && fl_at != 2));
      if (wbe && fl_at != 2) begin
         chk("wb_addr", 32'(wb_addr), 32'(rd));
         chk("wb_data", wb_data, res);
      end
      tick();
      flush = 1'b0;
      #1;
      if (fl_at != 2) m_flags = nf;
      chk("post_ready", 32'(op_if.in_ready), 32'd1);
      chk("post_done", 32'(done), 32'd0);
      chk("post_flags", 32'(flags_nzcv), 32'(m_flags));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      op_if.in_valid  = 1'b0;
      op_if.in_cond   = 4'hE;
      op_if.in_opcode = 4'h0;
      op_if.in_s      = 1'b0;
      op_if.in_rd     = '0;
      op_if.in_op1    = '0;
      op_if.in_op2    = '0;
      op_if.in_shc    = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(op_if.in_ready), 32'd1);
      chk("rst_wben", 32'(wb_en), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cpass", 32'(cond_pass), 32'd0);
      chk("rst_waddr", 32'(wb_addr), 32'd0);
      chk("rst_wdata", wb_data, 32'd0);
      chk("rst_flags", 32'(flags_nzcv), 32'd0);
      chk("rst_aop", 32'(alu_opcode), 32'hD);
      chk("rst_op1", alu_operand1, 32'd0);
      chk("rst_op2", alu_operand2, 32'd0);
      rst_n = 1'b1;

      do_op(4'hE, 4'h4, 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 0);
      chk("adds_nzcv", 32'(flags_nzcv), 32'b1001);
      do_op(4'h0, 4'hD, 1'b1, 4'd3, 32'd0, 32'd9, 1'b0, 0);
      do_op(4'hE, 4'hD, 1'b1, 4'd4, 32'd5, 32'd0, 1'b1, 0);
      chk("movs_nzcv", 32'(flags_nzcv), 32'b0111);
      do_op(4'hE, 4'hA, 1'b0, 4'd5, 32'd5, 32'd5, 1'b0, 0);
      chk("cmp_nzcv", 32'(flags_nzcv), 32'b0110);
      do_op(4'hE, 4'h4, 1'b1, 4'd6, 32'd1, 32'd2, 1'b0, 1);
      do_op(4'hE, 4'h2, 1'b1, 4'd7, 32'd1, 32'd2, 1'b0, 2);
      do_op(4'hE, 4'h3, 1'b1, 4'd8, 32'd1, 32'h8000_0000, 1'b0, 3);

      op_if.in_valid  = 1'b1;
      op_if.in_cond   = 4'hE;
      op_if.in_opcode = 4'hD;
      op_if.in_s      = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("b2b_ready", 32'(op_if.in_ready), 32'(i % 3 == 0));
         if (i == 5) op_if.in_valid = 1'b0;
         tick();
      end

      for (int i = 0; i < 60; i++) begin
         do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               pick(), pick(), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      do_op(4'hE, 4'hA, 1'b0, 4'd1, 32'd3, 32'd3, 1'b0, 0);
      op_if.in_valid  = 1'b1;
      op_if.in_opcode = 4'h4;
      op_if.in_s      = 1'b1;
      tick();
      op_if.in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_flags = 4'b0000;
      chk("mrst_ready", 32'(op_if.in_ready), 32'd1);
      chk("mrst_wben", 32'(wb_en), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_flags", 32'(flags_nzcv), 32'd0);
      do_op(4'hE, 4'h2, 1'b1, 4'd9, 32'd0, 32'd1, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
